lfsr_shift_engine: RTL

- Parametrised successor to the team's fixed 11-bit shift/LFSR register.
- Each step does one of four operations, selected by a mode input: hold, serial shift-in, Fibonacci LFSR with a programmable tap mask, or rotate.
- Adds a counted serial burst output with valid/ready handshake and a done pulse, plus all-zero lock-up recovery.
- Feeds scrambler/PRBS and serial-bit paths in the FPGA datapath.

---
 rtl/lfsr_shift_engine_if.sv | 31 +++
 rtl/lfsr_shift_engine.sv | 114 +++++++++++
 2 files changed

// File: rtl/lfsr_shift_engine_if.sv
// Bundles the control, burst handshake and status signals of lfsr_shift_engine.
// The master modport belongs to whoever drives the engine. The slave modport
// belongs to the engine itself.
interface lfsr_shift_engine_if #(
    parameter int WIDTH = 11,
    parameter int CNT_W = 16
);
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [1:0]       mode;
    logic             data_1;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic             bit_ready;
    logic [WIDTH-1:0] data_o;
    logic             bit_o;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             lockup;

    modport master (
        output load, load_data, mode, data_1, start, burst_len, bit_ready,
        input  data_o, bit_o, bit_valid, busy, done, lockup
    );

    modport slave (
        input  load, load_data, mode, data_1, start, burst_len, bit_ready,
        output data_o, bit_o, bit_valid, busy, done, lockup
    );
endinterface

// File: rtl/lfsr_shift_engine.sv
// Parametrised shift/LFSR register with a counted serial burst output.
// Every step shifts right and inserts a new MSB. bit_o is always the current LSB.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | free-running step each cycle; accepts load and start
// S_BURST | emits burst bits; steps only on a bit_valid && bit_ready handshake
module lfsr_shift_engine #(
    parameter int               WIDTH    = 11,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(11'h041),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1),
    parameter int               CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_shift_engine_if.slave  bus
);

    localparam logic [1:0] M_HOLD   = 2'b00;
    localparam logic [1:0] M_SHIFT  = 2'b01;
    localparam logic [1:0] M_LFSR   = 2'b10;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             lockup_q;

    logic [WIDTH-1:0] step_d;
    logic             recover_d;

    // Compute the value one step would produce, including all-zero LFSR recovery.
    always_comb begin
        step_d    = data_q;
        recover_d = 1'b0;
        case (bus.mode)
            M_HOLD:  step_d = data_q;
            M_SHIFT: step_d = {bus.data_1, data_q[WIDTH-1:1]};
            M_LFSR: begin
                // An all-zero LFSR never leaves zero, so reseed and flag it.
                if (data_q == '0) begin
                    step_d    = RST_SEED;
                    recover_d = 1'b1;
                end else begin
                    step_d = {^(data_q & TAP_MASK), data_q[WIDTH-1:1]};
                end
            end
            default: step_d = {data_q[0], data_q[WIDTH-1:1]};
        endcase
    end

    // Control FSM plus datapath and status registers. All outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            data_q   <= RST_SEED;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        data_q   <= bus.load_data;
                        lockup_q <= 1'b0;
                    end else if (!bus.start) begin
                        data_q <= step_d;
                        if (recover_d) lockup_q <= 1'b1;
                    end
                    if (bus.start) begin
                        cnt_q <= bus.burst_len;
                        if (bus.burst_len != '0) begin
                            state_q <= S_BURST;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            // A zero-length burst completes immediately without emitting bits.
                            done_q <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (bus.bit_ready) begin
                        data_q <= step_d;
                        if (recover_d) lockup_q <= 1'b1;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.data_o    = data_q;
    assign bus.bit_o     = data_q[0];
    assign bus.bit_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.lockup    = lockup_q;

endmodule
